mem_rd_ctrl: RTL and testbench

MEM_RD_CTRL -- requirements
Module: mem_rd_ctrl

---
 rtl/mem_rd_ctrl_pkg.sv | 15 +
 rtl/mem_rd_ctrl_access_timer.sv | 37 +++
 rtl/mem_rd_ctrl.sv | 138 +++++++++++++
 tb/tb_mem_rd_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_rd_ctrl_pkg.sv
// Shared definitions for the memory read/write controller: state encoding,
// timer width and the default access timeout.
package mem_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOAD = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam int TIMER_W         = 8;
  localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_rd_ctrl_access_timer.sv
// Saturating WAIT-cycle counter; hit flags that the current cycle is the
// TIMEOUT-th cycle spent waiting (or later).
module access_timer
  import mem_rd_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != {TIMER_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // count_q holds the WAIT cycles already completed, so +1 includes this one.
  assign hit = ({1'b0, count_q} + 9'd1) >= 9'(TIMEOUT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_rd_ctrl.sv
// Memory access controller: latches one read or write request, drives the
// memory strobe until ack or timeout, and hands read data to the data register.
module mem_rd_ctrl
  import mem_rd_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        bus_2_dr,
  output logic              data_on_dr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic [7:0]          bus_2_dr_q, bus_2_dr_d;
  logic                data_on_dr_q, data_on_dr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                timer_clr, timer_en, timer_hit;

  access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clr),
    .enable (timer_en),
    .hit    (timer_hit)
  );

  always_comb begin
    state_d      = state_q;
    mem_req_d    = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    bus_2_dr_d   = bus_2_dr_q;
    data_on_dr_d = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    timer_clr    = 1'b0;
    timer_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_clr = 1'b1;
        if (rd_req || wr_req) begin
          state_d    = ST_WAIT;
          mem_req_d  = 1'b1;
          // A read always wins; the colliding write is not latched at all.
          mem_we_d   = !rd_req;
          mem_addr_d = addr;
          if (!rd_req) begin
            mem_wdata_d = wdata;
          end
        end
      end
      ST_WAIT: begin
        timer_en = 1'b1;
        if (mem_ack) begin
          done_d = 1'b1;
          if (mem_we_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d      = ST_LOAD;
            bus_2_dr_d   = mem_rdata;
            data_on_dr_d = 1'b1;
          end
        end else if (timer_hit) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = mem_we_q;
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      bus_2_dr_q   <= '0;
      data_on_dr_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      bus_2_dr_q   <= bus_2_dr_d;
      data_on_dr_q <= data_on_dr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign bus_2_dr   = bus_2_dr_q;
  assign data_on_dr = data_on_dr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_rd_ctrl.sv
// Directed, table-driven bench for mem_rd_ctrl (TIMEOUT = 4) plus hand-written
// back-to-back sequences.
module tb_mem_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_req, wr_req, mem_ack;
  logic [7:0] addr, wdata, mem_rdata;
  logic       mem_req, mem_we, data_on_dr, busy, done, err;
  logic [7:0] mem_addr, mem_wdata, bus_2_dr;

  always #5 clk = ~clk;

  mem_rd_ctrl #(.ADDR_W(8), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_req     (rd_req),
    .wr_req     (wr_req),
    .addr       (addr),
    .wdata      (wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .bus_2_dr   (bus_2_dr),
    .data_on_dr (data_on_dr),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct packed {
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] dr;
    logic       dod;
    logic       done;
    logic       err;
    logic       busy;
  } out_t;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       rd;
    logic       wr;
    logic [7:0] a;
    logic [7:0] wd;
    logic       ack;
    logic [7:0] rdat;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];
  int   passes = 0;
  int   total  = 0;

  function automatic out_t o(logic req, logic we, logic [7:0] a, logic [7:0] wd,
                             logic [7:0] dr, logic dod, logic dn, logic er, logic bz);
    out_t r;
    r = '{req, we, a, wd, dr, dod, dn, er, bz};
    return r;
  endfunction

  task automatic add(string name, logic rst_n, logic rd, logic wr, logic [7:0] a,
                     logic [7:0] wd, logic ack, logic [7:0] rdat, out_t exp);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd;
    v.ack = ack; v.rdat = rdat; v.exp = exp;
    vecs.push_back(v);
  endtask

  function automatic out_t cur();
    out_t r;
    r = '{mem_req, mem_we, mem_addr, mem_wdata, bus_2_dr, data_on_dr, done, err, busy};
    return r;
  endfunction

  task automatic chk_out(string name, out_t exp);
    out_t got;
    got = cur();
    total++;
    if (got === exp) begin
      passes++;
      $display("vec %-16s req=%0b we=%0b addr=%02h wd=%02h dr=%02h dod=%0b done=%0b err=%0b busy=%0b ok",
               name, got.req, got.we, got.addr, got.wdata, got.dr, got.dod, got.done, got.err, got.busy);
    end else begin
      $display("FAIL %s got req=%0b we=%0b addr=%02h wd=%02h dr=%02h dod=%0b done=%0b err=%0b busy=%0b expected req=%0b we=%0b addr=%02h wd=%02h dr=%02h dod=%0b done=%0b err=%0b busy=%0b",
               name, got.req, got.we, got.addr, got.wdata, got.dr, got.dod, got.done, got.err, got.busy,
               exp.req, exp.we, exp.addr, exp.wdata, exp.dr, exp.dod, exp.done, exp.err, exp.busy);
    end
  endtask

  task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
    total++;
    if (got === exp) begin
      passes++;
      $display("seq %-16s got=%02h ok", name, got);
    end else begin
      $display("FAIL %s got=%02h expected=%02h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic seen;

    // name, rst_n, rd, wr, addr, wdata, ack, rdata, expected outputs after the edge
    add("reset",        0, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(0,0,8'h00,8'h00,8'h00,0,0,0,0));
    add("rd_accept",    1, 1, 0, 8'h3C, 8'h00, 0, 8'h00, o(1,0,8'h3C,8'h00,8'h00,0,0,0,1));
    add("rd_wait2",     1, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(1,0,8'h3C,8'h00,8'h00,0,0,0,1));
    add("rd_load",      1, 0, 0, 8'h00, 8'h00, 1, 8'hA5, o(0,0,8'h3C,8'h00,8'hA5,1,1,0,1));
    add("rd_idle",      1, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(0,0,8'h3C,8'h00,8'hA5,0,0,0,0));
    add("wr_accept",    1, 0, 1, 8'h10, 8'h5A, 0, 8'h00, o(1,1,8'h10,8'h5A,8'hA5,0,0,0,1));
    add("wr_done",      1, 0, 0, 8'h00, 8'h00, 1, 8'hFF, o(0,0,8'h10,8'h5A,8'hA5,0,1,0,0));
    add("wr_idle",      1, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(0,0,8'h10,8'h5A,8'hA5,0,0,0,0));
    add("to_wait1",     1, 1, 0, 8'h77, 8'h00, 0, 8'h00, o(1,0,8'h77,8'h5A,8'hA5,0,0,0,1));
    add("to_wait2",     1, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(1,0,8'h77,8'h5A,8'hA5,0,0,0,1));
    add("to_wait3",     1, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(1,0,8'h77,8'h5A,8'hA5,0,0,0,1));
    add("to_wait4",     1, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(1,0,8'h77,8'h5A,8'hA5,0,0,0,1));
    add("to_err",       1, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(0,0,8'h77,8'h5A,8'hA5,0,0,1,1));
    add("to_idle",      1, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(0,0,8'h77,8'h5A,8'hA5,0,0,0,0));
    add("both_accept",  1, 1, 1, 8'h21, 8'hC3, 0, 8'h00, o(1,0,8'h21,8'h5A,8'hA5,0,0,0,1));
    add("both_wait2",   1, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(1,0,8'h21,8'h5A,8'hA5,0,0,0,1));
    add("both_wait3",   1, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(1,0,8'h21,8'h5A,8'hA5,0,0,0,1));
    add("both_wait4",   1, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(1,0,8'h21,8'h5A,8'hA5,0,0,0,1));
    add("ack_at_limit", 1, 0, 0, 8'h00, 8'h00, 1, 8'h3E, o(0,0,8'h21,8'h5A,8'h3E,1,1,0,1));
    add("limit_idle",   1, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(0,0,8'h21,8'h5A,8'h3E,0,0,0,0));
    add("mid_accept",   1, 1, 0, 8'h99, 8'h00, 0, 8'h00, o(1,0,8'h99,8'h5A,8'h3E,0,0,0,1));
    add("mid_reset",    0, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(0,0,8'h00,8'h00,8'h00,0,0,0,0));
    add("stray_ack",    1, 0, 0, 8'h00, 8'h00, 1, 8'h55, o(0,0,8'h00,8'h00,8'h00,0,0,0,0));
    add("post_stray",   1, 0, 0, 8'h00, 8'h00, 0, 8'h00, o(0,0,8'h00,8'h00,8'h00,0,0,0,0));

    foreach (vecs[i]) begin
      rst       = vecs[i].rst_n;
      rd_req    = vecs[i].rd;
      wr_req    = vecs[i].wr;
      addr      = vecs[i].a;
      wdata     = vecs[i].wd;
      mem_ack   = vecs[i].ack;
      mem_rdata = vecs[i].rdat;
      step();
      chk_out(vecs[i].name, vecs[i].exp);
    end

    // Read request held high: one access, then a new one from the first IDLE cycle.
    rd_req = 1'b1; addr = 8'h40; mem_ack = 1'b0;
    step();
    chk("hold_req1", {7'd0, mem_req}, 8'h01);
    mem_ack = 1'b1; mem_rdata = 8'h81;
    step();
    chk("hold_load_dod", {7'd0, data_on_dr}, 8'h01);
    chk("hold_load_data", bus_2_dr, 8'h81);
    mem_ack = 1'b0;
    step();
    chk("hold_idle", {6'd0, busy, mem_req}, 8'h00);
    step();
    chk("hold_req2", {7'd0, mem_req}, 8'h01);
    chk("hold_addr2", mem_addr, 8'h40);
    rd_req = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h18;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      mem_ack = 1'b0;
      if (data_on_dr) seen = 1'b1;
    end
    chk("hold_second_dod", {7'd0, seen}, 8'h01);
    chk("hold_second_data", bus_2_dr, 8'h18);
    step();

    // Write held high: accepted again in the done cycle.
    wr_req = 1'b1; addr = 8'h55; wdata = 8'h66;
    step();
    chk("wr_b2b_we", {6'd0, mem_req, mem_we}, 8'h03);
    mem_ack = 1'b1;
    step();
    chk("wr_b2b_done", {6'd0, done, busy}, 8'h02);
    mem_ack = 1'b0;
    step();
    chk("wr_b2b_restart", {6'd0, mem_req, mem_we}, 8'h03);
    wr_req = 1'b0; mem_ack = 1'b1;
    step();
    chk("wr_b2b_done2", {6'd0, done, data_on_dr}, 8'h02);
    mem_ack = 1'b0;
    step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
